// File: rtl/reg_array_mp.sv
// reg_array_mp: parametrised multi-port register file.
//
// There are two write ports, A and B. Each write is first captured in a staged register. It is
// committed to the bank on the following clock edge. When both staged writes target the same
// entry, port B wins. Read addresses are registered, and read data is combinational from the
// registered address. When BYPASS is set, staged write data is forwarded to any read port whose
// registered address matches it.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (clears bank, staged writes, read addresses)
//   pause        stall: holds the write stage and the read-address registers
//   rd_clk_cls   holds the read-address registers only
//   wren_a/b     write enables (B has priority on address collision)
//   wraddress_a/b, data_a/b   write address / data
//   rdaddress    NRD packed read addresses, port k = [k*AW +: AW]
//   q            NRD packed read data,      port k = [k*DW +: DW]
module reg_array_mp #(
   parameter int unsigned DW       = 32,
   parameter int unsigned AW       = 5,
   parameter int unsigned NRD      = 2,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pause,
   input  logic              rd_clk_cls,
   input  logic              wren_a,
   input  logic [AW-1:0]     wraddress_a,
   input  logic [DW-1:0]     data_a,
   input  logic              wren_b,
   input  logic [AW-1:0]     wraddress_b,
   input  logic [DW-1:0]     data_b,
   input  logic [NRD*AW-1:0] rdaddress,
   output logic [NRD*DW-1:0] q
);

   localparam int unsigned Depth = 2 ** AW;

   logic          r_wren_a, r_wren_b;
   logic [AW-1:0] r_wa_a, r_wa_b;
   logic [DW-1:0] r_d_a, r_d_b;
   logic [AW-1:0] r_ra [NRD];
   logic [DW-1:0] bank [Depth];

   logic commit_a, commit_b;

   // Staged write registers; frozen while the pipeline is paused.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wren_a <= 1'b0;
         r_wren_b <= 1'b0;
         r_wa_a   <= '0;
         r_wa_b   <= '0;
         r_d_a    <= '0;
         r_d_b    <= '0;
      end else if (!pause) begin
         r_wren_a <= wren_a;
         r_wren_b <= wren_b;
         r_wa_a   <= wraddress_a;
         r_wa_b   <= wraddress_b;
         r_d_a    <= data_a;
         r_d_b    <= data_b;
      end
   end

   // Read-address registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < NRD; k++) begin
            r_ra[k] <= '0;
         end
      end else if (!pause && !rd_clk_cls) begin
         for (int unsigned k = 0; k < NRD; k++) begin
            r_ra[k] <= rdaddress[k*AW +: AW];
         end
      end
   end

   // Writes to entry 0 are discarded when it is hardwired to zero. Port A also yields to port B
   // when both target the same entry.
   always_comb begin
      commit_b = r_wren_b && !(ZERO_REG && (r_wa_b == '0));
      commit_a = r_wren_a && !(ZERO_REG && (r_wa_a == '0))
                 && !(r_wren_b && (r_wa_b == r_wa_a));
   end

   // Commit happens on every edge, even while paused. Re-committing a held stage is harmless.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            bank[i] <= '0;
         end
      end else begin
         if (commit_a) bank[r_wa_a] <= r_d_a;
         if (commit_b) bank[r_wa_b] <= r_d_b;
      end
   end

   // Read mux. Port B is checked before port A so the bypass matches commit priority.
   always_comb begin
      q = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         if (ZERO_REG && (r_ra[k] == '0)) begin
            q[k*DW +: DW] = '0;
         end else if (BYPASS && r_wren_b && (r_wa_b == r_ra[k])) begin
            q[k*DW +: DW] = r_d_b;
         end else if (BYPASS && r_wren_a && (r_wa_a == r_ra[k])) begin
            q[k*DW +: DW] = r_d_a;
         end else begin
            q[k*DW +: DW] = bank[r_ra[k]];
         end
      end
   end

endmodule

// File: tb/tb_reg_array_mp.sv
// tb_reg_array_mp: directed bench for reg_array_mp.
// u_dut0: default parameters (32-bit, 32 entries, 2 read ports, zero register, bypass).
// u_dut1: 16-bit, 16 entries, 4 read ports, no zero register, no bypass.
// Expected read values are queued when stimulus is applied and compared after the clock edge.
module tb_reg_array_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, pause, rd_clk_cls;

   logic        wren_a0, wren_b0;
   logic [4:0]  wa_a0, wa_b0;
   logic [31:0] d_a0, d_b0;
   logic [9:0]  rd0;
   logic [63:0] q0;

   logic        wren_a1, wren_b1;
   logic [3:0]  wa_a1, wa_b1;
   logic [15:0] d_a1, d_b1;
   logic [15:0] rd1;
   logic [63:0] q1;

   reg_array_mp u_dut0 (
      .clk         (clk),
      .rst         (rst),
      .pause       (pause),
      .rd_clk_cls  (rd_clk_cls),
      .wren_a      (wren_a0),
      .wraddress_a (wa_a0),
      .data_a      (d_a0),
      .wren_b      (wren_b0),
      .wraddress_b (wa_b0),
      .data_b      (d_b0),
      .rdaddress   (rd0),
      .q           (q0)
   );

   reg_array_mp #(
      .DW       (16),
      .AW       (4),
      .NRD      (4),
      .ZERO_REG (1'b0),
      .BYPASS   (1'b0)
   ) u_dut1 (
      .clk         (clk),
      .rst         (rst),
      .pause       (pause),
      .rd_clk_cls  (rd_clk_cls),
      .wren_a      (wren_a1),
      .wraddress_a (wa_a1),
      .data_a      (d_a1),
      .wren_b      (wren_b1),
      .wraddress_b (wa_b1),
      .data_b      (d_b1),
      .rdaddress   (rd1),
      .q           (q1)
   );

   typedef struct {
      string       tag;
      int          unit;
      int          port;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int unit, input int port, input logic [31:0] v,
                           input string tag);
      exp_t e;
      e.tag  = tag;
      e.unit = unit;
      e.port = port;
      e.exp  = v;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] obs_of(input int unit, input int port);
      if (unit == 0) return q0[port*32 +: 32];
      return {16'h0, q1[port*16 +: 16]};
   endfunction

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = obs_of(e.unit, e.port);
         n_total++;
         assert (obs === e.exp) n_pass++;
         else $error("FAIL %s (dut%0d port %0d): observed %h, expected %h",
                     e.tag, e.unit, e.port, obs, e.exp);
      end
   endtask

   initial begin
      rst = 1'b1; pause = 1'b0; rd_clk_cls = 1'b0;
      wren_a0 = 1'b0; wren_b0 = 1'b0; wa_a0 = '0; wa_b0 = '0; d_a0 = '0; d_b0 = '0; rd0 = '0;
      wren_a1 = 1'b0; wren_b1 = 1'b0; wa_a1 = '0; wa_b1 = '0; d_a1 = '0; d_b1 = '0; rd1 = '0;
      step();
      step();
      for (int k = 0; k < 2; k++) push_exp(0, k, 32'h0, "reset_q");
      for (int k = 0; k < 4; k++) push_exp(1, k, 32'h0, "reset_q");
      drain();
      rst = 1'b0;

      // Load entry 5, then stage a write to 6 and reset before it commits.
      wren_a0 = 1'b1; wa_a0 = 5'd5; d_a0 = 32'h1234_5678; rd0[4:0] = 5'd5;
      step();
      push_exp(0, 0, 32'h1234_5678, "load5_bypass");
      drain();
      wren_a0 = 1'b0;
      step();
      push_exp(0, 0, 32'h1234_5678, "load5_bank");
      drain();
      wren_a0 = 1'b1; wa_a0 = 5'd6; d_a0 = 32'hCAFE_F00D; rd0[9:5] = 5'd6;
      step();
      push_exp(0, 1, 32'hCAFE_F00D, "stage6_bypass");
      drain();
      #2 rst = 1'b1;
      wren_a0 = 1'b0;
      #1;
      push_exp(0, 0, 32'h0, "rst_async");
      push_exp(0, 1, 32'h0, "rst_async");
      drain();
      step();
      #3 rst = 1'b0;
      step();
      push_exp(0, 0, 32'h0, "post_rst_addr5");
      push_exp(0, 1, 32'h0, "post_rst_lost6");
      drain();

      // Basic write then read, with and without bypass.
      wren_a0 = 1'b1; wa_a0 = 5'd3; d_a0 = 32'hDEAD_BEEF; rd0[4:0] = 5'd3;
      wren_a1 = 1'b1; wa_a1 = 4'd3; d_a1 = 16'hBEEF;     rd1[3:0] = 4'd3;
      step();
      push_exp(0, 0, 32'hDEAD_BEEF, "raw_bypass_e0");
      push_exp(1, 0, 32'h0, "raw_nobypass_e0");
      drain();
      wren_a0 = 1'b0; wren_a1 = 1'b0;
      step();
      push_exp(0, 0, 32'hDEAD_BEEF, "raw_bank_e1");
      push_exp(1, 0, 32'h0000_BEEF, "raw_nobypass_e1");
      drain();

      // Collision on entry 7: port B wins in both bypass and bank.
      wren_a0 = 1'b1; wa_a0 = 5'd7; d_a0 = 32'h1111;
      wren_b0 = 1'b1; wa_b0 = 5'd7; d_b0 = 32'h2222; rd0 = {5'd7, 5'd7};
      wren_a1 = 1'b1; wa_a1 = 4'd7; d_a1 = 16'h1111;
      wren_b1 = 1'b1; wa_b1 = 4'd7; d_b1 = 16'h2222; rd1[7:0] = {4'd7, 4'd7};
      step();
      push_exp(0, 0, 32'h2222, "coll_bypass");
      push_exp(0, 1, 32'h2222, "coll_bypass");
      drain();
      wren_a0 = 1'b0; wren_b0 = 1'b0; wren_a1 = 1'b0; wren_b1 = 1'b0;
      step();
      push_exp(0, 0, 32'h2222, "coll_bank");
      push_exp(0, 1, 32'h2222, "coll_bank");
      push_exp(1, 0, 32'h2222, "coll_nobypass");
      push_exp(1, 1, 32'h2222, "coll_nobypass");
      drain();

      // Entry 0: hardwired on dut0, ordinary on dut1.
      wren_b0 = 1'b1; wa_b0 = 5'd0; d_b0 = 32'hFFFF_FFFF; rd0[4:0] = 5'd0;
      wren_a1 = 1'b1; wa_a1 = 4'd0; d_a1 = 16'hFFFF;     rd1[3:0] = 4'd0;
      step();
      push_exp(0, 0, 32'h0, "zero_e0");
      drain();
      wren_b0 = 1'b0; wren_a1 = 1'b0;
      step();
      push_exp(0, 0, 32'h0, "zero_e1");
      push_exp(1, 0, 32'h0000_FFFF, "nozero_e1");
      drain();

      // Pause and read-clock-clear hold.
      wren_a0 = 1'b1; wa_a0 = 5'd9; d_a0 = 32'hA5; rd0[4:0] = 5'd9;
      step();
      wren_a0 = 1'b0;
      step();
      push_exp(0, 0, 32'hA5, "pre_pause");
      drain();
      pause = 1'b1; rd0[4:0] = 5'd10;
      wren_a0 = 1'b1; wa_a0 = 5'd10; d_a0 = 32'h55;
      step();
      step();
      push_exp(0, 0, 32'hA5, "pause_hold");
      drain();
      pause = 1'b0; rd_clk_cls = 1'b1; rd0 = {5'd10, 5'd11};
      wa_a0 = 5'd11; d_a0 = 32'h77;
      step();
      push_exp(0, 0, 32'hA5, "cls_hold_e0");
      push_exp(0, 1, 32'h2222, "cls_hold_p1");
      drain();
      wren_a0 = 1'b0;
      step();
      push_exp(0, 0, 32'hA5, "cls_hold_e1");
      drain();
      rd_clk_cls = 1'b0;
      step();
      push_exp(0, 0, 32'h77, "cls_write_advanced");
      push_exp(0, 1, 32'h0, "pause_blocked_write");
      drain();

      // Sweep on dut1: odd entries via port B, even via port A, four reads per cycle.
      for (int i = 1; i < 16; i++) begin
         if (i % 2 == 1) begin
            wren_b1 = 1'b1; wa_b1 = 4'(i); d_b1 = 16'(i); wren_a1 = 1'b0;
         end else begin
            wren_a1 = 1'b1; wa_a1 = 4'(i); d_a1 = 16'(i); wren_b1 = 1'b0;
         end
         step();
      end
      wren_a1 = 1'b0; wren_b1 = 1'b0;
      step();
      for (int g = 0; g < 4; g++) begin
         for (int k = 0; k < 4; k++) begin
            int a;
            a = g * 4 + 3 - k;
            rd1[k*4 +: 4] = 4'(a);
            push_exp(1, k, (a == 0) ? 32'h0000_FFFF : 32'(a), "sweep");
         end
         step();
         drain();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/reg_array_mp.md
# reg_array_mp

Parametrised multi-port register file for the mips789 datapath and successor cores. It generalises the single-write/dual-read register array to configurable data width, depth and read-port count, and adds a second write port with defined collision priority. It keeps the registered-address read path, the pause and read-clock-clear hold controls and write-through bypass. It sits between decode (read addresses), writeback (write ports) and the operand forwarding muxes.

## Interface
- DW, 32, data width in bits
- AW, 5, address width; depth = 2**AW entries
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, entry 0 always reads 0 and writes to it are discarded
- BYPASS, 1, when 1, staged write data is forwarded to matching read ports
- Reset is asynchronous and active-high; one clock.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- pause  in  1  pipeline stall; blocks capture of write-stage and read-address registers
- rd_clk_cls  in  1  holds the read-address registers (independent of pause)
- wren_a  in  1  write enable, port A
- wraddress_a  in  AW  write address, port A
- data_a  in  DW  write data, port A
- wren_b  in  1  write enable, port B (higher priority)
- wraddress_b  in  AW  write address, port B
- data_b  in  DW  write data, port B
- rdaddress  in  NRD*AW  read addresses; port k = bits [k*AW +: AW]
- q  out  NRD*DW  read data; port k = bits [k*DW +: DW]

## Operation
- Write stage: on clk with pause=0, capture {wren, wraddress, data} for both ports into staged registers r_wren_x, r_wa_x, r_d_x. With pause=1, the staged registers hold.
- Commit: on every clk, write staged entries with r_wren_x=1 to the bank, regardless of pause. A repeated commit during pause is idempotent.
- Collision: if r_wren_a=r_wren_b=1 and r_wa_a==r_wa_b, only port B is committed.
- ZERO_REG=1: a staged write to address 0 is dropped, both at commit and in the bypass.
- Read-address stage: on clk with pause=0 and rd_clk_cls=0, capture all NRD addresses into r_ra[k]. Otherwise r_ra holds.
- Read data for port k is combinational from r_ra[k], using the first matching case:
  - ZERO_REG and r_ra[k]==0: returns 0.
  - BYPASS, r_wren_b, and r_wa_b==r_ra[k]: returns r_d_b.
  - BYPASS, r_wren_a, and r_wa_a==r_ra[k]: returns r_d_a.
  - Otherwise: returns bank[r_ra[k]].
- Reset (asynchronous, any time including mid-write):
  - Clears all bank entries, staged write registers (r_wren_x=0) and r_ra.
  - All q outputs are 0 while rst is high and after release.
  - A write staged when rst asserts is lost.

## Timing
- Write latency: data presented before edge E0 (pause=0) is staged at E0 and committed at E1.
- Read-after-write with BYPASS=1: visible on q immediately after E0 if r_ra matches.
- Read-after-write with BYPASS=0: visible after E1.
- Read latency: an address presented before edge E0 (pause=0, rd_clk_cls=0) selects q after E0. q is combinational from that point.
- During pause: q stays stable apart from changes in bank content under held r_ra. With held staged writes and bypass on, q is constant.
- No combinational path from any input to q.

## Test plan
- Reset: load entry 5 = 0x12345678, then assert rst mid-cycle -> q all 0 asynchronously; reading address 5 after release -> 0.
- Basic write/read: wren_a=1, wraddress_a=3, data_a=0xDEADBEEF at E0; rdaddress port 0 = 3 at E0 -> q[0] = 0xDEADBEEF after E0 via bypass. With BYPASS=0, q[0] = 0xDEADBEEF only after E1.
- Collision: both ports write address 7, A=0x1111, B=0x2222 -> bypass and bank both hold 0x2222. Ports 0 and 1 both reading 7 -> 0x2222.
- Zero register: write 0xFFFFFFFF to address 0 -> q for address 0 stays 0. With ZERO_REG=0 -> reads 0xFFFFFFFF after E1.
- Pause/hold: read address 9 (=0xA5), then pause=1 while rdaddress changes to 10 -> q stays 0xA5. Same with rd_clk_cls=1, pause=0 -> q stays 0xA5 while the write stage still advances.
- Parameter sweep: DW=16, AW=4, NRD=4. Write distinct values 0x0001..0x000F to addresses 1..15, read four addresses per cycle -> every q[k] matches its address's written value.
